ps2_rx_fifo: RTL and testbench

- PS/2 device-to-host receiver for the keyboard path. It sits directly upstream of the scan-code FSM in the top level.
- Synchronises the raw ps2_clk/ps2_data lines, deframes 11-bit frames (start, 8 data bits LSB-first, odd parity, stop) and validates them.
- Valid bytes are pushed into a small FIFO. The FIFO is exposed through the ready/nextdata_n/overflow handshake the scan-code FSM already consumes.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_rx_fifo_sync_fifo.sv | 47 ++++
 rtl/ps2_rx_fifo.sv | 122 ++++++++++++
 tb/tb_ps2_rx_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame layout, receiver state encoding and the
// scan-code constants used by the downstream scan-code FSM.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic        START_BIT      = 1'b0;
  localparam logic        STOP_BIT       = 1'b1;

  localparam logic [7:0]  BREAK_CODE     = 8'hF0;
  localparam logic [7:0]  EXT_CODE       = 8'hE0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_CHECK
  } rx_state_t;

  // Frame is held LSB-first: [0]=start, [8:1]=data, [9]=odd parity, [10]=stop.
  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[0] == START_BIT) && (f[10] == STOP_BIT) && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Parameterised synchronous byte FIFO with extra-MSB pointers. A push into a
// full FIFO only succeeds when a pop happens on the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the pad lines, deframes and
// validates 11-bit frames, and queues good bytes behind a ready/nextdata_n FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_IDX = 4'(PS2_FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0]    clk_sync;
  logic [SYNC_STAGES-1:0]    data_sync;
  logic                      clk_prev;
  logic                      fall;
  logic                      sample;

  rx_state_t                 state;
  logic [3:0]                bit_cnt;
  logic [PS2_FRAME_BITS-1:0] shreg;
  logic [WD_W-1:0]           wd;

  logic                      push;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      fifo_drop;

  assign fall   = clk_prev && !clk_sync[SYNC_STAGES-1];
  assign sample = data_sync[SYNC_STAGES-1];

  // Synchronisers idle high so reset never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  // Push is decoded straight from CHECK so the write lands on the next edge.
  assign push = (state == RX_CHECK) && frame_ok(shreg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      wd        <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (fifo_drop) overflow <= 1'b1;
      case (state)
        RX_IDLE: begin
          wd <= '0;
          if (fall && (sample == START_BIT)) begin
            shreg   <= {sample, shreg[PS2_FRAME_BITS-1:1]};
            bit_cnt <= 4'd1;
            state   <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (fall) begin
            shreg   <= {sample, shreg[PS2_FRAME_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            wd      <= '0;
            if (bit_cnt == LAST_IDX) state <= RX_CHECK;
          end else if (wd == WD_MAX) begin
            frame_err <= 1'b1;
            bit_cnt   <= '0;
            wd        <= '0;
            state     <= RX_IDLE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        RX_CHECK: begin
          if (!frame_ok(shreg)) frame_err <= 1'b1;
          bit_cnt <= '0;
          wd      <= '0;
          state   <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shreg[8:1]),
    .pop   (!nextdata_n),
    .dout  (data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign ready = !fifo_empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames driven on the raw PS/2 lines,
// expected bytes and flags hand-derived per step.
module tb_ps2_rx_fifo;

  localparam int HP = 20;       // PS/2 half bit period in clk cycles
  localparam int TO = 400;      // shortened watchdog for simulation

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (8),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nbits of a frame; the stop-bit low phase is cycle-exact
  // so the push latency and a coincident pop can be placed on known edges.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input bit lat_chk, input bit pop_push);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cycles(HP);
      ps2_clk = 1'b0;
      if (i == 10) begin
        cycles(3);
        if (lat_chk) chk("latency_ready_low", {7'd0, ready}, 8'h00);
        if (pop_push) nextdata_n = 1'b0;
        cycles(1);
        nextdata_n = 1'b1;
        if (lat_chk) chk("latency_ready_high", {7'd0, ready}, 8'h01);
        cycles(HP - 4);
      end else begin
        cycles(HP);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cycles(HP);
  endtask

  task automatic pop_once();
    nextdata_n = 1'b0;
    cycles(1);
    nextdata_n = 1'b1;
    cycles(1);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk({tag, "_ready"}, {7'd0, ready}, 8'h01);
    chk(tag, data, exp);
    pop_once();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(2);
  endtask

  initial begin
    // Reset state
    cycles(3);
    chk("rst_ready", {7'd0, ready}, 8'h00);
    chk("rst_overflow", {7'd0, overflow}, 8'h00);
    chk("rst_frame_err", {7'd0, frame_err}, 8'h00);
    chk("rst_data", data, 8'h00);
    rst = 1'b0;
    cycles(2);

    // Single frame with push latency check, then a one-cycle pop
    send_frame(8'h1C, 1'b0, 11, 1'b1, 1'b0);
    chk("one_data", data, 8'h1C);
    chk("one_frame_err", {7'd0, frame_err}, 8'h00);
    pop_once();
    chk("one_ready_after_pop", {7'd0, ready}, 8'h00);

    // Three queued frames drain in order
    send_frame(8'h1C, 1'b0, 11, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 11, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 11, 1'b0, 1'b0);
    pop_expect("q0", 8'h1C);
    pop_expect("q1", 8'hF0);
    pop_expect("q2", 8'h1C);
    chk("q_empty", {7'd0, ready}, 8'h00);

    // Overflow: nine frames into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 11, 1'b0, 1'b0);
    chk("ovf_flag", {7'd0, overflow}, 8'h01);
    for (int i = 1; i <= 8; i++) pop_expect("ovf_drain", 8'(i));
    chk("ovf_empty", {7'd0, ready}, 8'h00);
    chk("ovf_sticky", {7'd0, overflow}, 8'h01);

    // Full FIFO with a pop coinciding with the push: nothing lost
    do_reset();
    chk("full_ovf_cleared", {7'd0, overflow}, 8'h00);
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 11, 1'b0, 1'b0);
    chk("full_ovf_before", {7'd0, overflow}, 8'h00);
    send_frame(8'h19, 1'b0, 11, 1'b0, 1'b1);
    chk("full_ovf_after", {7'd0, overflow}, 8'h00);
    for (int i = 0; i < 8; i++) pop_expect("full_drain", 8'h12 + 8'(i));
    chk("full_empty", {7'd0, ready}, 8'h00);

    // Parity error, then a good frame
    chk("par_err_before", {7'd0, frame_err}, 8'h00);
    send_frame(8'h1C, 1'b1, 11, 1'b0, 1'b0);
    chk("par_not_pushed", {7'd0, ready}, 8'h00);
    chk("par_frame_err", {7'd0, frame_err}, 8'h01);
    send_frame(8'h32, 1'b0, 11, 1'b0, 1'b0);
    pop_expect("par_next", 8'h32);
    chk("par_err_sticky", {7'd0, frame_err}, 8'h01);

    // Timeout after 5 bits
    do_reset();
    send_frame(8'h5A, 1'b0, 5, 1'b0, 1'b0);
    cycles(100);
    chk("to_not_yet", {7'd0, frame_err}, 8'h00);
    cycles(TO);
    chk("to_frame_err", {7'd0, frame_err}, 8'h01);
    chk("to_no_push", {7'd0, ready}, 8'h00);
    send_frame(8'h24, 1'b0, 11, 1'b0, 1'b0);
    pop_expect("to_next", 8'h24);
    chk("to_empty", {7'd0, ready}, 8'h00);

    // Reset mid-frame with bytes queued and sticky flags set
    do_reset();
    for (int i = 0; i < 9; i++) send_frame(8'hA0 + 8'(i), 1'b0, 11, 1'b0, 1'b0);
    send_frame(8'h77, 1'b1, 11, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) pop_once();
    chk("mid_ovf_set", {7'd0, overflow}, 8'h01);
    chk("mid_err_set", {7'd0, frame_err}, 8'h01);
    chk("mid_queued", {7'd0, ready}, 8'h01);
    send_frame(8'h66, 1'b0, 4, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("mid_rst_ready", {7'd0, ready}, 8'h00);
    chk("mid_rst_overflow", {7'd0, overflow}, 8'h00);
    chk("mid_rst_frame_err", {7'd0, frame_err}, 8'h00);
    chk("mid_rst_data", data, 8'h00);
    cycles(3);
    rst = 1'b0;
    cycles(2);
    send_frame(8'h45, 1'b0, 11, 1'b0, 1'b0);
    pop_expect("mid_next", 8'h45);
    chk("mid_final_empty", {7'd0, ready}, 8'h00);
    chk("mid_final_err", {7'd0, frame_err}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
